// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the decode-stage multi-port register file:
// default geometry, zero-register index and clear-sequencer state encoding.
package regfile_multiport_pkg;

  localparam int unsigned Word    = 64;
  localparam int unsigned NumRegs = 32;
  localparam int unsigned XzrIdx  = 31;

  typedef enum logic {
    RfClear = 1'b0,
    RfReady = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: write-to-read bypass, zero-register mask and
// output register. Outputs zero while the array is being cleared.
module regfile_read_port #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] rd_data_d, rd_data_q;

  // Later assignments take priority: clear beats zero register beats bypass.
  always_comb begin
    rd_data_d = mem_data;
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
    if (ZERO_EN && (rd_addr == AW'(ZERO_IDX))) begin
      rd_data_d = '0;
    end
    if (clear) begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with bypass, optional zero register
// and a clear sequencer that zeroes every entry after reset.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int unsigned WIDTH    = Word,
  parameter int unsigned DEPTH    = NumRegs,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = XzrIdx,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    ready
);

  rf_state_e        state_q;
  logic [AW-1:0]    clr_cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             clearing;
  logic             wr_accept;
  logic             wr_commit;

  assign clearing  = (state_q == RfClear);
  assign wr_accept = !clearing && wr_en;
  assign wr_commit = wr_accept && !(ZERO_EN && (wr_addr == AW'(ZERO_IDX)));
  assign ready     = (state_q == RfReady);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RfClear;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RfClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RfReady;
          end
        end
        RfReady: state_q <= RfReady;
        default: state_q <= RfClear;
      endcase
    end
  end

  // Array has no reset of its own; the sequencer walks it after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_commit) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];

    regfile_read_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_EN  (ZERO_EN),
      .ZERO_IDX (ZERO_IDX)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .clear    (clearing),
      .rd_addr  (addr),
      .mem_data (mem_q[addr]),
      .wr_en    (wr_accept),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
